// File: rtl/upd7800_clkgen.sv
// Two-phase non-overlapping CPU clock generator for a uPD7800-style core.
// Produces CP1/CP2 levels and edge strobes from one system clock, with HOLD freeze and stretched CPU reset.
module upd7800_clkgen #(
  parameter int DIV        = 8,
  parameter int RST_CYCLES = 4
) (
  input  logic CLK,
  input  logic RESETB,
  input  logic HOLD,
  output logic CP1,
  output logic CP2,
  output logic CP1_POSEDGE,
  output logic CP1_NEGEDGE,
  output logic CP2_POSEDGE,
  output logic CP2_NEGEDGE,
  output logic CPU_RESETB,
  output logic HOLD_ACK
);

  localparam int CW = $clog2(DIV);
  localparam int RW = $clog2(RST_CYCLES + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF   = CW'(DIV / 2);
  localparam logic [CW-1:0] CNT_GAP1   = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_C1_END = CW'(DIV / 2 - 2);
  localparam logic [CW-1:0] CNT_C2_END = CW'(DIV - 2);
  localparam logic [RW-1:0] RCNT_MAX   = RW'(RST_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          cp1_q, cp1_d;
  logic          cp2_q, cp2_d;
  logic          cp1_pos_q, cp1_pos_d;
  logic          cp1_neg_q, cp1_neg_d;
  logic          cp2_pos_q, cp2_pos_d;
  logic          cp2_neg_q, cp2_neg_d;
  logic          cpu_resetb_q, cpu_resetb_d;
  logic          hold_ack_q, hold_ack_d;
  logic          advance;

  // NOTE: every signal written here gets a value on every path, so no latches are inferred.
  always_comb begin
    // HOLD only matters at the end-of-period gap; staying there is the frozen state.
    advance = !((cnt_q == CNT_LAST) && HOLD);
    cnt_d   = cnt_q;
    if (advance) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);

    cp1_d     = (cnt_d <= CNT_C1_END);
    cp2_d     = (cnt_d >= CNT_HALF) && (cnt_d <= CNT_C2_END);
    cp1_pos_d = advance && (cnt_d == '0);
    cp1_neg_d = advance && (cnt_d == CNT_GAP1);
    cp2_pos_d = advance && (cnt_d == CNT_HALF);
    cp2_neg_d = advance && (cnt_d == CNT_LAST);
    hold_ack_d = !advance;

    rcnt_d = rcnt_q;
    if (cp1_pos_d && (rcnt_q != RCNT_MAX)) rcnt_d = rcnt_q + RW'(1);

    // Release at the end of the period in which rcnt saturated, ahead of the next CP1 rise.
    cpu_resetb_d = cpu_resetb_q | (cp2_neg_d && (rcnt_q == RCNT_MAX));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      cnt_q        <= CNT_LAST;
      rcnt_q       <= '0;
      cp1_q        <= 1'b0;
      cp2_q        <= 1'b0;
      cp1_pos_q    <= 1'b0;
      cp1_neg_q    <= 1'b0;
      cp2_pos_q    <= 1'b0;
      cp2_neg_q    <= 1'b0;
      cpu_resetb_q <= 1'b0;
      hold_ack_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      rcnt_q       <= rcnt_d;
      cp1_q        <= cp1_d;
      cp2_q        <= cp2_d;
      cp1_pos_q    <= cp1_pos_d;
      cp1_neg_q    <= cp1_neg_d;
      cp2_pos_q    <= cp2_pos_d;
      cp2_neg_q    <= cp2_neg_d;
      cpu_resetb_q <= cpu_resetb_d;
      hold_ack_q   <= hold_ack_d;
    end
  end

  assign CP1         = cp1_q;
  assign CP2         = cp2_q;
  assign CP1_POSEDGE = cp1_pos_q;
  assign CP1_NEGEDGE = cp1_neg_q;
  assign CP2_POSEDGE = cp2_pos_q;
  assign CP2_NEGEDGE = cp2_neg_q;
  assign CPU_RESETB  = cpu_resetb_q;
  assign HOLD_ACK    = hold_ack_q;

endmodule

// File: tb/tb_upd7800_clkgen.sv
// Directed bench for upd7800_clkgen (DIV=8, RST_CYCLES=4).
// Output vector: {CP1, CP2, CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE, CP2_NEGEDGE, CPU_RESETB, HOLD_ACK}.
module tb_upd7800_clkgen;

  logic clk = 1'b0;
  logic resetb, hold;
  logic cp1, cp2, cp1_pos, cp1_neg, cp2_pos, cp2_neg, cpu_resetb, hold_ack;
  int   n_cmp = 0;
  int   n_bad = 0;

  upd7800_clkgen #(.DIV(8), .RST_CYCLES(4)) dut (
    .CLK(clk), .RESETB(resetb), .HOLD(hold),
    .CP1(cp1), .CP2(cp2),
    .CP1_POSEDGE(cp1_pos), .CP1_NEGEDGE(cp1_neg),
    .CP2_POSEDGE(cp2_pos), .CP2_NEGEDGE(cp2_neg),
    .CPU_RESETB(cpu_resetb), .HOLD_ACK(hold_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {cp1, cp2, cp1_pos, cp1_neg, cp2_pos, cp2_neg, cpu_resetb, hold_ack};
  endfunction

  // Hand-derived levels/strobes for the k-th edge of a period (k=0 is the CP1 rise).
  function automatic logic [5:0] phase_pat(int k);
    case (k % 8)
      0:       return 6'b10_1000;
      1, 2:    return 6'b10_0000;
      3:       return 6'b00_0100;
      4:       return 6'b01_0010;
      5, 6:    return 6'b01_0000;
      default: return 6'b00_0001;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Apply inputs away from the edge, let one rising edge pass, settle before sampling.
  task automatic tick(input logic rb, input logic h);
    resetb = rb;
    hold   = h;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    repeat (3) tick(1'b0, 1'b0);
    check("reset_state", obs(), 8'b0);
  endtask

  initial begin
    resetb = 1'b0;
    hold   = 1'b0;

    // Free-running after release: 8-edge period, CPU_RESETB rises at edge 32.
    do_reset();
    for (int n = 1; n <= 40; n++) begin
      tick(1'b1, 1'b0);
      check($sformatf("run_e%0d", n), obs(), {phase_pat(n - 1), n >= 32, 1'b0});
    end

    // HOLD sampled high on edges 3..20: period completes, freeze 9..20, resume at 21.
    do_reset();
    for (int n = 1; n <= 30; n++) begin
      tick(1'b1, (n >= 3) && (n <= 20));
      if (n <= 8)       check($sformatf("hold_e%0d", n), obs(), {phase_pat(n - 1), 2'b00});
      else if (n <= 20) check($sformatf("hold_e%0d", n), obs(), 8'b0000_0001);
      else              check($sformatf("hold_e%0d", n), obs(), {phase_pat(n - 21), 2'b00});
    end

    // HOLD pulsed mid-period (edge 5, cnt=4) is ignored.
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      tick(1'b1, n == 5);
      check($sformatf("pulse_e%0d", n), obs(), {phase_pat(n - 1), 2'b00});
    end

    // Reset asserted while cnt=5 aborts the period; re-release restarts stretching.
    do_reset();
    for (int n = 1; n <= 6; n++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("midreset_abort", obs(), 8'b0);
    for (int n = 1; n <= 33; n++) begin
      tick(1'b1, 1'b0);
      check($sformatf("rerel_e%0d", n), obs(), {phase_pat(n - 1), n >= 32, 1'b0});
    end

    // Release with HOLD high: frozen from edge 1; rcnt starts at the strobe on edge 6.
    do_reset();
    for (int n = 1; n <= 40; n++) begin
      tick(1'b1, n <= 5);
      if (n <= 5) check($sformatf("relhold_e%0d", n), obs(), 8'b0000_0001);
      else        check($sformatf("relhold_e%0d", n), obs(), {phase_pat(n - 6), n >= 37, 1'b0});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/upd7800_clkgen.md
UPD7800_CLKGEN -- requirements
Module: upd7800_clkgen

Interface
REQ-001 SHALL have parameter DIV, default 8: CLK cycles per CPU clock period; even, >= 4.
REQ-002 SHALL have parameter RST_CYCLES, default 4: number of CPU periods CPU_RESETB is held low after RESETB release; >= 1.
REQ-003 SHALL have port CLK  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port RESETB  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port HOLD  input  1  request to freeze CPU clocking at the end of the current period.
REQ-006 SHALL have port CP1  output  1  phase-1 level.
REQ-007 SHALL have port CP2  output  1  phase-2 level.
REQ-008 SHALL have port CP1_POSEDGE  output  1  one-CLK strobe on the first cycle CP1 is high.
REQ-009 SHALL have port CP1_NEGEDGE  output  1  one-CLK strobe on the first cycle CP1 is low after being high.
REQ-010 SHALL have port CP2_POSEDGE  output  1  one-CLK strobe on the first cycle CP2 is high.
REQ-011 SHALL have port CP2_NEGEDGE  output  1  one-CLK strobe on the first cycle CP2 is low after being high.
REQ-012 SHALL have port CPU_RESETB  output  1  stretched active-low reset to the CPU core.
REQ-013 SHALL have port HOLD_ACK  output  1  high while clocking is frozen.

Function
REQ-014 SHALL keep a phase counter cnt in 0..DIV-1 that advances by 1 per CLK and wraps DIV-1 -> 0.
REQ-015 SHALL drive CP1=1 iff cnt in 0..DIV/2-2, and CP2=1 iff cnt in DIV/2..DIV-2. cnt=DIV/2-1 and cnt=DIV-1 are non-overlap gaps with both phases low.
REQ-016 SHALL register all outputs, so each is a function of state after the same CLK edge; no combinational path from any input to any output.
REQ-017 SHALL assert each strobe only on the CLK cycle in which cnt has just changed into its value: 0, DIV/2-1, DIV/2, DIV-1 respectively.
REQ-018 SHALL never assert a strobe twice without cnt advancing, including while frozen.
REQ-019 SHALL, when cnt=DIV-1 and HOLD=1, keep cnt at DIV-1 and set HOLD_ACK=1 on the following cycle.
REQ-020 SHALL keep HOLD_ACK=1 and all strobes 0 while frozen.
REQ-021 SHALL ignore HOLD at every other cnt value; the current period always completes.
REQ-022 SHALL, when HOLD is sampled 0 while frozen, advance cnt to 0 on that edge, clear HOLD_ACK, and assert CP1_POSEDGE.
REQ-023 SHALL hold a reset counter rcnt (width clog2(RST_CYCLES+1)) that increments on every CLK edge that produces a CP1_POSEDGE strobe, saturating at RST_CYCLES.
REQ-024 SHALL drive CPU_RESETB low until rcnt=RST_CYCLES.
REQ-025 SHALL raise CPU_RESETB on the edge producing the CP2_NEGEDGE strobe of the period in which rcnt reached RST_CYCLES, so it is stable before the next CP1_POSEDGE.
REQ-026 SHALL keep CPU_RESETB high once raised, until RESETB is asserted.
REQ-027 SHALL continue counting rcnt during HOLD periods, but only at CP1_POSEDGE events; frozen cycles do not count.

Reset
REQ-028 SHALL, on any CLK edge with RESETB=0, set cnt=DIV-1, rcnt=0, and CP1=CP2=0, all four strobes 0, CPU_RESETB=0, HOLD_ACK=0, regardless of cnt or HOLD.
REQ-029 SHALL, on the first edge with RESETB=1, advance cnt to 0 and assert CP1_POSEDGE if HOLD=0. If HOLD=1 on that edge it SHALL enter the frozen state instead.
REQ-030 SHALL abort the phase sequence immediately, with no completion of the period, when reset is asserted mid-period.

Verification (DIV=8, RST_CYCLES=4; edge n = nth edge after RESETB release, HOLD=0 unless stated)
REQ-031 Release reset -> edge 1: CP1=1, CP1_POSEDGE=1; edge 4: CP1_NEGEDGE; edge 5: CP2_POSEDGE, CP2=1; edge 8: CP2_NEGEDGE; edge 9: CP1_POSEDGE. Period is 8 and CP1·CP2 is never 1.
REQ-032 Release reset -> CPU_RESETB=0 through edge 31 and 1 from edge 32 (the 4th CP2_NEGEDGE) onward. Exactly one strobe of each kind per 8 edges.
REQ-033 HOLD=1 from edge 3 through edge 20 -> CP2_NEGEDGE at edge 8; HOLD_ACK=1 at edges 9..20 with no strobes. Edge 21 (HOLD sampled 0) -> CP1_POSEDGE=1, HOLD_ACK=0.
REQ-034 HOLD pulsed high only on edge 5 (cnt=4) -> no freeze; the strobe pattern is identical to REQ-031.
REQ-035 RESETB low while cnt=5 -> next edge: CP2=0, all strobes 0, CPU_RESETB=0. Re-release -> CP1_POSEDGE on the 1st edge and CPU_RESETB high again only after 4 more periods (edge 32).
REQ-036 Reset released with HOLD=1 -> HOLD_ACK=1 from edge 1, no strobes, CPU_RESETB=0. Dropping HOLD -> CP1_POSEDGE on the next edge; rcnt starts at that strobe.
